// File: rtl/watch_pkg.sv
// Shared types and helpers for the watch user-interface sequencer.
package watch_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL    = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_ALARM     = 2'd2,
        MODE_STOPWATCH = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        FLD_H_TENS  = 2'd0,
        FLD_H_UNITS = 2'd1,
        FLD_M_TENS  = 2'd2,
        FLD_M_UNITS = 2'd3
    } field_e;

    localparam int IDLE_W = 6;

    function automatic mode_e next_mode(input mode_e cur);
        case (cur)
            MODE_NORMAL:    next_mode = MODE_SET_TIME;
            MODE_SET_TIME:  next_mode = MODE_ALARM;
            MODE_ALARM:     next_mode = MODE_STOPWATCH;
            MODE_STOPWATCH: next_mode = MODE_NORMAL;
            default:        next_mode = MODE_NORMAL;
        endcase
    endfunction

    function automatic logic is_edit_mode(input mode_e cur);
        is_edit_mode = (cur == MODE_SET_TIME) || (cur == MODE_ALARM);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Raw push-button conditioner: two-flop synchronizer followed by a registered
// rising-edge pulse. The synchronized level is exported for hold detection.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse,
    output logic level
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic pulse_r;

    // Synchronize, keep one cycle of history and register the rising edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            pulse_r <= sync2_r & ~prev_r;
        end
    end

    assign pulse = pulse_r;
    assign level = sync2_r;

endmodule

// File: rtl/watch_mode_ctrl.sv
// Watch UI sequencer: button conditioning, display-mode FSM, edit cursor, command strobes.
// Build macro WATCH_CTRL_AUTOREPEAT_EN adds auto-repeat of a held toggle in the edit modes.
module watch_mode_ctrl
    import watch_pkg::*;
#(
    parameter int TIMEOUT_S      = 30,
    parameter int RPT_HOLD_CYC   = 1000,
    parameter int RPT_PERIOD_CYC = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       toggle_btn,
    input  logic       confirm_btn,
    input  logic       tick_1hz,
    output logic [1:0] mode,
    output logic [1:0] edit_field,
    output logic       field_inc,
    output logic       commit_time,
    output logic       commit_alarm,
    output logic       edit_abort,
    output logic       time_hold,
    output logic       alarm_armed,
    output logic       alarm_silence,
    output logic       sw_running,
    output logic       sw_lap,
    output logic       sw_clear
);

    localparam logic [IDLE_W-1:0] TIMEOUT_V = IDLE_W'(TIMEOUT_S);

    logic              mode_ev_s, toggle_pulse_s, confirm_ev_s, toggle_ev_s, rpt_s, edit_s;
    logic              mode_lvl_s, toggle_lvl_s, confirm_lvl_s, unused_s;
    mode_e             mode_r, mode_s;
    field_e            field_r, field_s;
    logic [IDLE_W-1:0] idle_r, idle_s;
    logic              armed_r, armed_s, run_r, run_s, hold_r, hold_s;
    logic              inc_r, inc_s, ct_r, ct_s, ca_r, ca_s, abort_r, abort_s;
    logic              sil_r, sil_s, lap_r, lap_s, clr_r, clr_s;

    btn_edge u_mode_edge (
        .clk(clk), .rst(rst), .btn(mode_btn), .pulse(mode_ev_s), .level(mode_lvl_s)
    );
    btn_edge u_toggle_edge (
        .clk(clk), .rst(rst), .btn(toggle_btn), .pulse(toggle_pulse_s), .level(toggle_lvl_s)
    );
    btn_edge u_confirm_edge (
        .clk(clk), .rst(rst), .btn(confirm_btn), .pulse(confirm_ev_s), .level(confirm_lvl_s)
    );

    assign edit_s      = is_edit_mode(mode_r);
    assign toggle_ev_s = toggle_pulse_s | rpt_s;

`ifdef WATCH_CTRL_AUTOREPEAT_EN
    logic [15:0] hold_cnt_r;

    // Repeat fires once the hold window elapses, then once per repeat period
    always_comb begin
        if (toggle_lvl_s && edit_s) begin
            rpt_s = (hold_cnt_r == 16'(RPT_HOLD_CYC - 1));
        end else begin
            rpt_s = 1'b0;
        end
    end

    // Hold-duration counter restarts on release or when leaving the edit modes
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_cnt_r <= 16'd0;
        end else if (!(toggle_lvl_s && edit_s)) begin
            hold_cnt_r <= 16'd0;
        end else if (rpt_s) begin
            hold_cnt_r <= 16'(RPT_HOLD_CYC - RPT_PERIOD_CYC);
        end else begin
            hold_cnt_r <= hold_cnt_r + 16'd1;
        end
    end

    assign unused_s = mode_lvl_s ^ confirm_lvl_s;
`else
    assign rpt_s    = 1'b0;
    assign unused_s = ^{mode_lvl_s, confirm_lvl_s, toggle_lvl_s,
                        RPT_HOLD_CYC[0], RPT_PERIOD_CYC[0]};
`endif

    // Next state and strobes; mode beats confirm beats toggle beats timeout
    always_comb begin
        mode_s  = mode_r;
        field_s = field_r;
        idle_s  = idle_r;
        armed_s = armed_r;
        run_s   = run_r;
        inc_s   = 1'b0;
        ct_s    = 1'b0;
        ca_s    = 1'b0;
        abort_s = 1'b0;
        sil_s   = 1'b0;
        lap_s   = 1'b0;
        clr_s   = 1'b0;
        if (mode_ev_s) begin
            mode_s  = next_mode(mode_r);
            field_s = FLD_H_TENS;
            idle_s  = {IDLE_W{1'b0}};
            abort_s = edit_s;
        end else if (confirm_ev_s) begin
            idle_s = {IDLE_W{1'b0}};
            case (mode_r)
                MODE_SET_TIME, MODE_ALARM: begin
                    if (field_r == FLD_M_UNITS) begin
                        field_s = FLD_H_TENS;
                        ct_s    = (mode_r == MODE_SET_TIME);
                        ca_s    = (mode_r == MODE_ALARM);
                        armed_s = armed_r | (mode_r == MODE_ALARM);
                    end else begin
                        field_s = field_e'(field_r + 2'd1);
                    end
                end
                MODE_NORMAL:    armed_s = ~armed_r;
                MODE_STOPWATCH: begin
                    lap_s = run_r;
                    clr_s = ~run_r;
                end
                default:        armed_s = armed_r;
            endcase
        end else if (toggle_ev_s) begin
            idle_s = {IDLE_W{1'b0}};
            case (mode_r)
                MODE_SET_TIME, MODE_ALARM: inc_s = 1'b1;
                MODE_NORMAL:               sil_s = 1'b1;
                MODE_STOPWATCH:            run_s = ~run_r;
                default:                   inc_s = 1'b0;
            endcase
        end else if (tick_1hz && edit_s) begin
            if (idle_r + 6'd1 == TIMEOUT_V) begin
                mode_s  = MODE_NORMAL;
                field_s = FLD_H_TENS;
                idle_s  = {IDLE_W{1'b0}};
                abort_s = 1'b1;
            end else begin
                idle_s = idle_r + 6'd1;
            end
        end else begin
            idle_s = idle_r;
        end
        hold_s = (mode_s == MODE_SET_TIME);
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_r  <= MODE_NORMAL;
            field_r <= FLD_H_TENS;
            idle_r  <= {IDLE_W{1'b0}};
            armed_r <= 1'b0;
            run_r   <= 1'b0;
            hold_r  <= 1'b0;
            inc_r   <= 1'b0;
            ct_r    <= 1'b0;
            ca_r    <= 1'b0;
            abort_r <= 1'b0;
            sil_r   <= 1'b0;
            lap_r   <= 1'b0;
            clr_r   <= 1'b0;
        end else begin
            mode_r  <= mode_s;
            field_r <= field_s;
            idle_r  <= idle_s;
            armed_r <= armed_s;
            run_r   <= run_s;
            hold_r  <= hold_s;
            inc_r   <= inc_s;
            ct_r    <= ct_s;
            ca_r    <= ca_s;
            abort_r <= abort_s;
            sil_r   <= sil_s;
            lap_r   <= lap_s;
            clr_r   <= clr_s;
        end
    end

    assign mode          = mode_r;
    assign edit_field    = field_r;
    assign field_inc     = inc_r;
    assign commit_time   = ct_r;
    assign commit_alarm  = ca_r;
    assign edit_abort    = abort_r;
    assign time_hold     = hold_r;
    assign alarm_armed   = armed_r;
    assign alarm_silence = sil_r;
    assign sw_running    = run_r;
    assign sw_lap        = lap_r;
    assign sw_clear      = clr_r;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Scoreboard bench for watch_mode_ctrl: a behavioural model predicts every cycle's outputs.
module tb_watch_mode_ctrl;

    localparam int TIMEOUT = 30;
    localparam int LAT     = 3;

    logic       clk, rst, mode_btn, toggle_btn, confirm_btn, tick_1hz;
    logic [1:0] mode, edit_field;
    logic       field_inc, commit_time, commit_alarm, edit_abort, time_hold;
    logic       alarm_armed, alarm_silence, sw_running, sw_lap, sw_clear;

    watch_mode_ctrl dut (
        .clk(clk), .rst(rst), .mode_btn(mode_btn), .toggle_btn(toggle_btn),
        .confirm_btn(confirm_btn), .tick_1hz(tick_1hz), .mode(mode),
        .edit_field(edit_field), .field_inc(field_inc), .commit_time(commit_time),
        .commit_alarm(commit_alarm), .edit_abort(edit_abort), .time_hold(time_hold),
        .alarm_armed(alarm_armed), .alarm_silence(alarm_silence),
        .sw_running(sw_running), .sw_lap(sw_lap), .sw_clear(sw_clear)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {int due; bit m; bit t; bit c;} ev_t;
    ev_t         pend_q[$];
    logic [13:0] exp_q[$];
    int checks = 0, failures = 0, cyc = 0;
    int m_mode = 0, m_field = 0, m_idle = 0;
    bit m_armed = 0, m_run = 0, prev_m = 0, prev_t = 0, prev_c = 0;
    int abort_cnt = 0, ct_cnt = 0, ca_cnt = 0, inc_cnt = 0, sil_cnt = 0, lap_cnt = 0, clr_cnt = 0;

    function automatic logic [13:0] act_vec();
        return {mode, edit_field, field_inc, commit_time, commit_alarm, edit_abort,
                time_hold, alarm_armed, alarm_silence, sw_running, sw_lap, sw_clear};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Behavioural model: a rise sampled at edge c acts at edge c+LAT
    task automatic model_edge(input bit r, input bit m, input bit t, input bit c, input bit tk);
        bit em = 0, et = 0, ec = 0, edit;
        bit inc = 0, ct = 0, ca = 0, ab = 0, sil = 0, lap = 0, clr = 0;
        cyc++;
        if (!r) begin
            m_mode = 0; m_field = 0; m_idle = 0; m_armed = 0; m_run = 0;
            prev_m = 0; prev_t = 0; prev_c = 0;
            pend_q.delete();
            exp_q.push_back(14'd0);
            return;
        end
        while (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            ev_t x;
            x  = pend_q.pop_front();
            em = em | x.m; et = et | x.t; ec = ec | x.c;
        end
        if ((m && !prev_m) || (t && !prev_t) || (c && !prev_c))
            pend_q.push_back('{due: cyc + LAT, m: m && !prev_m, t: t && !prev_t, c: c && !prev_c});
        prev_m = m; prev_t = t; prev_c = c;
        edit = (m_mode == 1) || (m_mode == 2);
        if (em) begin
            ab = edit; m_mode = (m_mode + 1) % 4; m_field = 0; m_idle = 0;
        end else if (ec) begin
            m_idle = 0;
            if (edit) begin
                if (m_field == 3) begin
                    if (m_mode == 1) ct = 1;
                    else begin ca = 1; m_armed = 1; end
                    m_field = 0;
                end else m_field++;
            end else if (m_mode == 0) m_armed = !m_armed;
            else if (m_run) lap = 1;
            else clr = 1;
        end else if (et) begin
            m_idle = 0;
            if (edit) inc = 1;
            else if (m_mode == 0) sil = 1;
            else m_run = !m_run;
        end else if (tk && edit) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin m_mode = 0; m_field = 0; m_idle = 0; ab = 1; end
        end
        exp_q.push_back({2'(m_mode), 2'(m_field), inc, ct, ca, ab, m_mode == 1, m_armed,
                         sil, m_run, lap, clr});
    endtask

    // Monitor: pops one prediction per cycle and compares away from the active edge
    always @(negedge clk) begin
        logic [13:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_vec();
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL outputs t=%0t actual=%b expected=%b", $time, a, e);
            end
            if (edit_abort === 1'b1)   abort_cnt++;
            if (commit_time === 1'b1)  ct_cnt++;
            if (commit_alarm === 1'b1) ca_cnt++;
            if (field_inc === 1'b1)    inc_cnt++;
            if (alarm_silence === 1'b1) sil_cnt++;
            if (sw_lap === 1'b1)       lap_cnt++;
            if (sw_clear === 1'b1)     clr_cnt++;
        end
    end

    task automatic step(input bit m, input bit t, input bit c, input bit tk, input bit r);
        @(negedge clk);
        mode_btn = m; toggle_btn = t; confirm_btn = c; tick_1hz = tk; rst = r;
        @(posedge clk);
        model_edge(r, m, t, c, tk);
    endtask

    task automatic press(input bit m, input bit t, input bit c, input int hold);
        repeat (hold) step(m, t, c, 1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        int hm = 0, ht = 0, hc = 0;
        rst = 1'b0; mode_btn = 1'b0; toggle_btn = 1'b0; confirm_btn = 1'b0; tick_1hz = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check("reset_outputs", int'(act_vec()), 0);
        // mode cycle with aborts leaving the edit modes
        abort_cnt = 0;
        repeat (4) press(1'b1, 1'b0, 1'b0, 2);
        check("mode_cycle_aborts", abort_cnt, 2);
        // Set_Time: two increments, four confirms, one commit
        press(1'b1, 1'b0, 1'b0, 2);
        ct_cnt = 0; inc_cnt = 0;
        repeat (2) press(1'b0, 1'b1, 1'b0, 3);
        repeat (4) press(1'b0, 1'b0, 1'b1, 2);
        check("set_time_incs", inc_cnt, 2);
        check("set_time_commit", ct_cnt, 1);
        // Alarm commit arms, Normal confirm disarms, toggle silences
        press(1'b1, 1'b0, 1'b0, 2);
        ca_cnt = 0; sil_cnt = 0;
        repeat (4) press(1'b0, 1'b0, 1'b1, 2);
        #1 check("alarm_armed_set", int'(alarm_armed), 1);
        check("alarm_commit", ca_cnt, 1);
        repeat (2) press(1'b1, 1'b0, 1'b0, 2);
        press(1'b0, 1'b0, 1'b1, 2);
        #1 check("alarm_disarmed", int'(alarm_armed), 0);
        press(1'b0, 1'b1, 1'b0, 2);
        check("silence", sil_cnt, 1);
        // Stopwatch run/lap/clear, running survives leaving the mode
        repeat (3) press(1'b1, 1'b0, 1'b0, 2);
        lap_cnt = 0; clr_cnt = 0;
        press(1'b0, 1'b1, 1'b0, 2);
        #1 check("sw_started", int'(sw_running), 1);
        press(1'b0, 1'b0, 1'b1, 2);
        press(1'b0, 1'b1, 1'b0, 2);
        press(1'b0, 1'b0, 1'b1, 2);
        check("sw_lap_clear", lap_cnt * 10 + clr_cnt, 11);
        press(1'b0, 1'b1, 1'b0, 2);
        press(1'b1, 1'b0, 1'b0, 2);
        #1 check("sw_background", int'(sw_running), 1);
        // Timeout in Alarm on the 30th tick
        repeat (2) press(1'b1, 1'b0, 1'b0, 2);
        ticks(TIMEOUT - 1);
        #1 check("before_timeout", int'(mode), 2);
        abort_cnt = 0;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1 check("timeout_mode", int'(mode), 0);
        check("timeout_abort", int'(edit_abort), 1);
        // Button event coinciding with the 30th tick wins
        repeat (2) press(1'b1, 1'b0, 1'b0, 2);
        ticks(TIMEOUT - 1);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        #1 check("no_timeout", int'(mode), 2);
        press(1'b0, 1'b0, 1'b0, 1);
        // Alarm -> Set_Time, field 3, then mode+confirm together
        repeat (3) press(1'b1, 1'b0, 1'b0, 2);
        repeat (3) press(1'b0, 1'b0, 1'b1, 2);
        ct_cnt = 0;
        press(1'b1, 1'b0, 1'b1, 2);
        #1 check("simul_mode", int'(mode), 2);
        check("simul_no_commit", ct_cnt, 0);
        inc_cnt = 0;
        press(1'b0, 1'b1, 1'b0, 1);
        check("glitch_one_inc", inc_cnt, 1);
        press(1'b0, 1'b0, 1'b1, 2);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check("reset_mid_edit", int'(act_vec()), 0);
        // Randomized phases: busy buttons, then sparse buttons with dense ticks
        for (int i = 0; i < 3000; i++) begin
            int bp, tp;
            bit mb, tb, cb, tk, r;
            bp = (i < 1500) ? 30 : 300;
            tp = (i < 1500) ? 8 : 2;
            if (hm == 0 && $urandom_range(bp - 1, 0) == 0) hm = $urandom_range(5, 1);
            if (ht == 0 && $urandom_range(bp - 1, 0) == 0) ht = $urandom_range(5, 1);
            if (hc == 0 && $urandom_range(bp - 1, 0) == 0) hc = $urandom_range(5, 1);
            mb = (hm > 0); tb = (ht > 0); cb = (hc > 0);
            if (hm > 0) hm--;
            if (ht > 0) ht--;
            if (hc > 0) hc--;
            tk = ($urandom_range(tp - 1, 0) == 0);
            r  = ($urandom_range(999, 0) != 0);
            step(mb, tb, cb, tk, r);
        end
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #1 check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
